dot_scan_arbiter: RTL and testbench
===================================

DOT_SCAN_ARBITER -- requirements
Module: dot_scan_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8: maximum cycles rd_req stays high waiting for an ack, range 2..255.
REQ-002 Parameter BLANK_ON_SWITCH, default 1: when 1, the first frame after an owner change is driven blank.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 tick  in  1  row-advance strobe, one-cycle pulse from the dot clock divider.
REQ-006 sel  in  1  requested display owner: 0 = heart game, 1 = mole game.
REQ-007 rd_req0 / rd_req1  out  1 each  row-fetch request to client 0 / client 1.
REQ-008 rd_row  out  3  row index being fetched; shared by both clients.
REQ-009 rd_ack0 / rd_ack1  in  1 each  client response strobe; data is valid in the same cycle.
REQ-010 rd_data0 / rd_data1  in  16 each  column pattern from the client, 1 = lit.
REQ-011 dot_row  out  8  active-low one-hot row select.
REQ-012 dot_col  out  16  column drive.
REQ-013 owner  out  1  client currently granted the display.
REQ-014 frame_start  out  1  one-cycle pulse when the row-0 fetch is issued.
REQ-015 err_overrun / err_timeout  out  1 each  one-cycle error pulses.

Function
REQ-016 The FSM SHALL have three states: IDLE (waiting for tick), FETCH (rd_req high, waiting for ack) and, entered only when BLANK_ON_SWITCH applies, BLANKFR (fetches suppressed).
REQ-017 On a tick in IDLE at cycle t, the block SHALL, at t+1:
  - assert rd_req of owner only;
  - drive rd_row = row counter;
  - drive dot_row = 8'hFF (anti-ghosting);
  - enter FETCH.
REQ-018 When the owner's rd_ack is high while its rd_req is high at cycle a, the block SHALL, at a+1:
  - drive dot_row = ~(8'h80 >> row), so row 0 gives 8'b0111_1111;
  - drive dot_col = the owner's rd_data captured at a;
  - deassert rd_req;
  - increment row modulo 8;
  - return to IDLE.
REQ-019 If no ack arrives within TIMEOUT cycles of rd_req high, the block SHALL drive the row with dot_col = 16'h0000, pulse err_timeout, advance the row and return to IDLE.
REQ-020 The non-owner's ack, and any ack while rd_req is low, SHALL be ignored.
REQ-021 A tick arriving in FETCH or BLANKFR SHALL be dropped with a one-cycle err_overrun pulse, and state SHALL be unaffected.
REQ-022 At the cycle the row-0 request is issued, the block SHALL:
  - load owner from sel;
  - pulse frame_start.
  owner SHALL never change mid-frame.
REQ-023 If owner changes and BLANK_ON_SWITCH = 1, that frame SHALL be blanked: each of its 8 ticks drives dot_row = 8'hFF, dot_col = 0 and issues no rd_req; normal fetching resumes at the next row 0.
REQ-024 The row counter SHALL wrap 7 -> 0; frame_start SHALL fire exactly once per 8 completed rows.

Reset
REQ-025 rst SHALL set the following at the next edge, including mid-FETCH:
  - state = IDLE, row = 0, owner = 0;
  - rd_req0 = rd_req1 = 0, rd_row = 0;
  - dot_row = 8'hFF, dot_col = 0;
  - frame_start = err_overrun = err_timeout = 0.
REQ-026 The first tick after reset SHALL fetch row 0 and be treated as a non-switch frame.

Structure
REQ-027 The shared package dot_pkg SHALL hold:
  - the FSM state encoding;
  - ROW_OFF = 8'hFF;
  - COL_BLANK = 16'h0000;
  - the row-select decode function.
REQ-028 The timeout counter SHALL be one sub-module, fetch_timer, with load/enable inputs and an expire output; everything else stays in dot_scan_arbiter.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
  - Reset, then tick with owner 0 and client 0 acking on the 2nd cycle with 16'hA55A -> rd_req0 high 2 cycles, then dot_row = 8'h7F and dot_col = 16'hA55A; frame_start pulses once.
  - 8 ticks with ack -> dot_row steps 7F, BF, DF, EF, F7, FB, FD, FE; the 9th tick re-pulses frame_start.
  - sel = 1 set at row 3 -> owner stays 0 until the row-0 request; with BLANK_ON_SWITCH = 1, 8 rows of FF/0000 and no rd_req1, then rd_req1 asserts.
  - Client never acks, TIMEOUT = 8 -> rd_req high exactly 8 cycles, err_timeout pulse, dot_col = 0000, row advances.
  - A second tick during FETCH, plus rd_ack1 asserted while owner = 0 -> err_overrun pulse, the ack is ignored, row advances once only.
  - rst asserted during FETCH -> next cycle rd_req0 = 0, dot_row = FF, row = 0.

Source files
------------

// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - shared state encoding, drive constants and row decode for the dot scan arbiter
package dot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_BLANKFR = 2'd2
  } dot_state_e;

  localparam logic [7:0]  ROW_OFF   = 8'hFF;
  localparam logic [15:0] COL_BLANK = 16'h0000;

  // Active-low one-hot select; row 0 drives the top line on bit 7.
  function automatic logic [7:0] row_select(input logic [2:0] row);
    return ~(8'h80 >> row);
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - counts cycles a row fetch has been outstanding
module fetch_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // The load coincides with rd_req rising, so the first request cycle reads 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 8'd1;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/dot_scan_arbiter.sv
// rtl/dot_scan_arbiter.sv - scans an 8-row dot matrix, fetching each row from one of two clients
module dot_scan_arbiter
  import dot_pkg::*;
#(
  parameter int TIMEOUT         = 8,
  parameter int BLANK_ON_SWITCH = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        sel_i,
  output logic        rd_req0_o,
  output logic        rd_req1_o,
  output logic [2:0]  rd_row_o,
  input  logic        rd_ack0_i,
  input  logic        rd_ack1_i,
  input  logic [15:0] rd_data0_i,
  input  logic [15:0] rd_data1_i,
  output logic [7:0]  dot_row_o,
  output logic [15:0] dot_col_o,
  output logic        owner_o,
  output logic        frame_start_o,
  output logic        err_overrun_o,
  output logic        err_timeout_o
);

  localparam logic BLANK_EN = (BLANK_ON_SWITCH != 0);

  dot_state_e  state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic        owner_q, owner_d;
  logic        first_q, first_d;
  logic        blank_q, blank_d;
  logic [7:0]  dot_row_q, dot_row_d;
  logic [15:0] dot_col_q, dot_col_d;
  logic        frame_start_q, frame_start_d;
  logic        err_overrun_q, err_overrun_d;
  logic        err_timeout_q, err_timeout_d;

  logic        timer_load;
  logic        timer_en;
  logic        timer_expire;
  logic        blank_now;
  logic        ack_own;
  logic [15:0] data_own;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (timer_load),
    .en_i     (timer_en),
    .expire_o (timer_expire)
  );

  assign ack_own  = owner_q ? rd_ack1_i  : rd_ack0_i;
  assign data_own = owner_q ? rd_data1_i : rd_data0_i;

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    owner_d       = owner_q;
    first_d       = first_q;
    blank_d       = blank_q;
    dot_row_d     = dot_row_q;
    dot_col_d     = dot_col_q;
    frame_start_d = 1'b0;
    err_overrun_d = 1'b0;
    err_timeout_d = 1'b0;
    timer_load    = 1'b0;
    timer_en      = 1'b0;
    blank_now     = blank_q;

    case (state_q)
      ST_IDLE: begin
        if (tick_i) begin
          // Ownership and the blanking decision are only revisited at a frame boundary.
          if (row_q == 3'd0) begin
            blank_now     = BLANK_EN && !first_q && (sel_i != owner_q);
            blank_d       = blank_now;
            owner_d       = sel_i;
            first_d       = 1'b0;
            frame_start_d = 1'b1;
          end
          dot_row_d = ROW_OFF;
          if (blank_now) begin
            dot_col_d = COL_BLANK;
            state_d   = ST_BLANKFR;
          end else begin
            timer_load = 1'b1;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        timer_en      = 1'b1;
        err_overrun_d = tick_i;
        if (ack_own) begin
          dot_row_d = row_select(row_q);
          dot_col_d = data_own;
          row_d     = row_q + 3'd1;
          state_d   = ST_IDLE;
        end else if (timer_expire) begin
          dot_row_d     = row_select(row_q);
          dot_col_d     = COL_BLANK;
          err_timeout_d = 1'b1;
          row_d         = row_q + 3'd1;
          state_d       = ST_IDLE;
        end
      end
      ST_BLANKFR: begin
        err_overrun_d = tick_i;
        row_d         = row_q + 3'd1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      row_q         <= 3'd0;
      owner_q       <= 1'b0;
      first_q       <= 1'b1;
      blank_q       <= 1'b0;
      dot_row_q     <= ROW_OFF;
      dot_col_q     <= COL_BLANK;
      frame_start_q <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      owner_q       <= owner_d;
      first_q       <= first_d;
      blank_q       <= blank_d;
      dot_row_q     <= dot_row_d;
      dot_col_q     <= dot_col_d;
      frame_start_q <= frame_start_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign rd_req0_o     = (state_q == ST_FETCH) && !owner_q;
  assign rd_req1_o     = (state_q == ST_FETCH) && owner_q;
  assign rd_row_o      = row_q;
  assign dot_row_o     = dot_row_q;
  assign dot_col_o     = dot_col_q;
  assign owner_o       = owner_q;
  assign frame_start_o = frame_start_q;
  assign err_overrun_o = err_overrun_q;
  assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_dot_scan_arbiter.sv
// tb/tb_dot_scan_arbiter.sv - directed bench with a row-transaction model of the scan arbiter
module tb_dot_scan_arbiter;

  localparam int TO    = 8;
  localparam int BLANK = 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tick_i;
  logic        sel_i;
  logic        rd_req0_o;
  logic        rd_req1_o;
  logic [2:0]  rd_row_o;
  logic        rd_ack0_i;
  logic        rd_ack1_i;
  logic [15:0] rd_data0_i;
  logic [15:0] rd_data1_i;
  logic [7:0]  dot_row_o;
  logic [15:0] dot_col_o;
  logic        owner_o;
  logic        frame_start_o;
  logic        err_overrun_o;
  logic        err_timeout_o;

  dot_scan_arbiter #(
    .TIMEOUT         (TO),
    .BLANK_ON_SWITCH (BLANK)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tick_i        (tick_i),
    .sel_i         (sel_i),
    .rd_req0_o     (rd_req0_o),
    .rd_req1_o     (rd_req1_o),
    .rd_row_o      (rd_row_o),
    .rd_ack0_i     (rd_ack0_i),
    .rd_ack1_i     (rd_ack1_i),
    .rd_data0_i    (rd_data0_i),
    .rd_data1_i    (rd_data1_i),
    .dot_row_o     (dot_row_o),
    .dot_col_o     (dot_col_o),
    .owner_o       (owner_o),
    .frame_start_o (frame_start_o),
    .err_overrun_o (err_overrun_o),
    .err_timeout_o (err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected outputs for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_req0, exp_req1, exp_owner, exp_fs, exp_ovr, exp_to;
  logic [2:0]  exp_rd_row;
  logic [7:0]  exp_dot_row;
  logic [15:0] exp_dot_col;

  // Model state
  int          m_row;
  bit          m_owner, m_first, m_blank;
  logic [7:0]  m_dot_row;
  logic [15:0] m_dot_col;

  // Counters and literal-check channel owned by the compare process / stimulus
  int n_cmp = 0;
  int n_bad = 0;
  int cnt_req = 0, cnt_req0 = 0, cnt_req1 = 0, cnt_fs = 0, cnt_ovr = 0, cnt_to = 0;
  string       lit_nm  [8];
  logic [15:0] lit_act [8];
  logic [15:0] lit_exp [8];
  int          lit_n = 0;
  int          lit_seq = 0;
  bit          lit_open = 1'b0;

  int b_req, b_req0, b_req1, b_fs, b_ovr, b_to;
  logic [7:0] seen [8];
  logic [7:0] row_tab [8];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, ex, $time);
    end
  endtask

  initial begin
    int lit_seen;
    lit_seen = 0;
    forever begin
      @(negedge clk_i);
      if (chk_en) begin
        chk("rd_req0", 16'(rd_req0_o), 16'(exp_req0));
        chk("rd_req1", 16'(rd_req1_o), 16'(exp_req1));
        chk("rd_row", 16'(rd_row_o), 16'(exp_rd_row));
        chk("dot_row", 16'(dot_row_o), 16'(exp_dot_row));
        chk("dot_col", dot_col_o, exp_dot_col);
        chk("owner", 16'(owner_o), 16'(exp_owner));
        chk("frame_start", 16'(frame_start_o), 16'(exp_fs));
        chk("err_overrun", 16'(err_overrun_o), 16'(exp_ovr));
        chk("err_timeout", 16'(err_timeout_o), 16'(exp_to));
        cnt_req  += int'(rd_req0_o | rd_req1_o);
        cnt_req0 += int'(rd_req0_o);
        cnt_req1 += int'(rd_req1_o);
        cnt_fs   += int'(frame_start_o);
        cnt_ovr  += int'(err_overrun_o);
        cnt_to   += int'(err_timeout_o);
        if (lit_seq != lit_seen) begin
          for (int i = 0; i < lit_n; i++) chk(lit_nm[i], lit_act[i], lit_exp[i]);
          lit_seen = lit_seq;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic lit_add(input string nm, input logic [15:0] act, input logic [15:0] ex);
    if (!lit_open) begin
      lit_n    = 0;
      lit_open = 1'b1;
    end
    if (lit_n < 8) begin
      lit_nm[lit_n]  = nm;
      lit_act[lit_n] = act;
      lit_exp[lit_n] = ex;
      lit_n++;
    end
  endtask

  task automatic lit_post();
    lit_open = 1'b0;
    lit_seq++;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    rd_ack0_i  = 1'b0;
    rd_ack1_i  = 1'b0;
    rd_data0_i = 16'h0000;
    rd_data1_i = 16'h0000;
  endtask

  function automatic logic [7:0] m_dec(input int r);
    return 8'hFF ^ (8'd1 << (7 - r));
  endfunction

  task automatic set_exp(input logic r0, input logic r1, input logic fs, input logic ovr, input logic to);
    exp_req0    = r0;
    exp_req1    = r1;
    exp_fs      = fs;
    exp_ovr     = ovr;
    exp_to      = to;
    exp_rd_row  = 3'(m_row);
    exp_dot_row = m_dot_row;
    exp_dot_col = m_dot_col;
    exp_owner   = m_owner;
  endtask

  task automatic m_reset();
    m_row     = 0;
    m_owner   = 1'b0;
    m_first   = 1'b1;
    m_blank   = 1'b0;
    m_dot_row = 8'hFF;
    m_dot_col = 16'h0000;
  endtask

  task automatic start_row(output bit blank);
    bit fs;
    fs = (m_row == 0);
    if (fs) begin
      blank   = (BLANK != 0) && !m_first && (sel_i != m_owner);
      m_blank = blank;
      m_first = 1'b0;
      m_owner = sel_i;
    end else begin
      blank = m_blank;
    end
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    m_dot_row = 8'hFF;
    if (blank) m_dot_col = 16'h0000;
    set_exp(!blank && !m_owner, !blank && m_owner, fs, 1'b0, 1'b0);
  endtask

  // ack_at: request cycle (1-based) in which the owner acks, 0 = never
  task automatic run_row(input int ack_at, input logic [15:0] d_own, input int extra_at, input bit foreign);
    bit blank, done, ovr;
    start_row(blank);
    if (blank) begin
      step();
      m_row = (m_row + 1) % 8;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      done = 1'b0;
      for (int k = 1; k <= TO && !done; k++) begin
        if (m_owner) begin
          rd_ack1_i = (k == ack_at);  rd_data1_i = d_own;
          rd_ack0_i = foreign;        rd_data0_i = 16'hFFFF;
        end else begin
          rd_ack0_i = (k == ack_at);  rd_data0_i = d_own;
          rd_ack1_i = foreign;        rd_data1_i = 16'hFFFF;
        end
        tick_i = (k == extra_at);
        step();
        tick_i = 1'b0;
        idle_inputs();
        ovr = (k == extra_at);
        if (k == ack_at) begin
          m_dot_row = m_dec(m_row);
          m_dot_col = d_own;
          m_row     = (m_row + 1) % 8;
          set_exp(1'b0, 1'b0, 1'b0, ovr, 1'b0);
          done = 1'b1;
        end else if (k == TO) begin
          m_dot_row = m_dec(m_row);
          m_dot_col = 16'h0000;
          m_row     = (m_row + 1) % 8;
          set_exp(1'b0, 1'b0, 1'b0, ovr, 1'b1);
          done = 1'b1;
        end else begin
          set_exp(!m_owner, m_owner, 1'b0, ovr, 1'b0);
        end
      end
    end
    // Acks with no request outstanding must change nothing.
    rd_ack0_i  = 1'b1;
    rd_ack1_i  = 1'b1;
    rd_data0_i = 16'hDEAD;
    rd_data1_i = 16'hBEEF;
    step();
    idle_inputs();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit b;
    row_tab = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    rst_i  = 1'b1;
    tick_i = 1'b0;
    sel_i  = 1'b0;
    idle_inputs();
    m_reset();

    step();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    lit_add("reset dot_row", 16'(dot_row_o), 16'h00FF);
    lit_add("reset rd_row", 16'(rd_row_o), 16'h0000);
    lit_post();
    rst_i = 1'b0;
    step();

    // First row: ack in the 2nd request cycle
    b_req0 = cnt_req0;
    b_fs   = cnt_fs;
    run_row(2, 16'hA55A, 0, 1'b0);
    seen[0] = dot_row_o;
    lit_add("row0 dot_row", 16'(dot_row_o), 16'h007F);
    lit_add("row0 dot_col", dot_col_o, 16'hA55A);
    lit_add("row0 req0 cycles", 16'(cnt_req0 - b_req0), 16'd2);
    lit_add("row0 frame_start count", 16'(cnt_fs - b_fs), 16'd1);
    lit_post();

    for (int i = 1; i < 8; i++) begin
      run_row(1 + (i % 3), 16'(i * 16'h1111), 0, 1'b0);
      seen[i] = dot_row_o;
    end
    for (int i = 0; i < 8; i++) lit_add($sformatf("row seq %0d", i), 16'(seen[i]), 16'(row_tab[i]));
    lit_post();

    b_fs = cnt_fs;
    run_row(1, 16'h0F0F, 0, 1'b0);
    lit_add("9th tick frame_start", 16'(cnt_fs - b_fs), 16'd1);
    lit_post();

    // Reset while a fetch is outstanding
    start_row(b);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    m_reset();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit_add("rst mid-fetch req0", 16'(rd_req0_o), 16'h0000);
    lit_add("rst mid-fetch dot_row", 16'(dot_row_o), 16'h00FF);
    lit_add("rst mid-fetch rd_row", 16'(rd_row_o), 16'h0000);
    lit_post();
    step();

    // Overrun tick plus non-owner ack during a fetch
    b_ovr = cnt_ovr;
    run_row(3, 16'h1234, 1, 1'b1);
    lit_add("overrun count", 16'(cnt_ovr - b_ovr), 16'd1);
    lit_add("overrun rd_row", 16'(rd_row_o), 16'd1);
    lit_add("overrun dot_col", dot_col_o, 16'h1234);
    lit_post();

    // Owner request changes mid-frame
    run_row(2, 16'h00FF, 0, 1'b0);
    run_row(1, 16'hFF00, 0, 1'b0);
    sel_i = 1'b1;
    for (int i = 3; i < 8; i++) run_row(1, 16'h3C3C, 0, 1'b0);
    lit_add("owner held mid-frame", 16'(owner_o), 16'h0000);
    lit_post();

    b_req = cnt_req;
    b_fs  = cnt_fs;
    for (int i = 0; i < 8; i++) run_row(1, 16'hFFFF, 0, 1'b0);
    lit_add("blank frame req cycles", 16'(cnt_req - b_req), 16'd0);
    lit_add("blank frame dot_row", 16'(dot_row_o), 16'h00FF);
    lit_add("blank frame dot_col", dot_col_o, 16'h0000);
    lit_add("blank frame frame_start", 16'(cnt_fs - b_fs), 16'd1);
    lit_post();

    b_req1 = cnt_req1;
    run_row(1, 16'h0F0F, 0, 1'b0);
    lit_add("post-blank req1 cycles", 16'(cnt_req1 - b_req1), 16'd1);
    lit_add("post-blank owner", 16'(owner_o), 16'h0001);
    lit_add("post-blank dot_col", dot_col_o, 16'h0F0F);
    lit_post();

    // Client never acks
    b_req = cnt_req;
    b_to  = cnt_to;
    run_row(0, 16'h5555, 0, 1'b0);
    lit_add("timeout req cycles", 16'(cnt_req - b_req), 16'd8);
    lit_add("timeout pulse count", 16'(cnt_to - b_to), 16'd1);
    lit_add("timeout dot_col", dot_col_o, 16'h0000);
    lit_add("timeout dot_row", 16'(dot_row_o), 16'h00BF);
    lit_add("timeout rd_row", 16'(rd_row_o), 16'd2);
    lit_post();

    step();
    step();
    chk_en = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
